// File: rtl/otter_pkg.sv
// otter_pkg: shared opcodes, FSM states, mux select codes and the EXECUTE control word
package otter_pkg;
  localparam int NUM_STATES = 5;
  localparam logic [2:0] MTVEC_SEL = 3'd4;
  typedef enum logic [6:0] {
    LUI    = 7'b0110111,
    AUIPC  = 7'b0010111,
    JAL    = 7'b1101111,
    JALR   = 7'b1100111,
    BRANCH = 7'b1100011,
    LOAD   = 7'b0000011,
    STORE  = 7'b0100011,
    OP_IMM = 7'b0010011,
    OP     = 7'b0110011,
    SYSTEM = 7'b1110011
  } opcode_t;
  typedef enum logic [$clog2(NUM_STATES)-1:0] {FETCH, DECODE, EXECUTE, WB, TRAP} state_t;
  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_TRAP   = MTVEC_SEL;
  localparam logic [1:0] RF_PC4  = 2'd0;
  localparam logic [1:0] RF_CSR  = 2'd1;
  localparam logic [1:0] RF_DMEM = 2'd2;
  localparam logic [1:0] RF_ALU  = 2'd3;
  typedef struct packed {
    logic       pc_write;
    logic [2:0] pc_sel;
    logic       mem_rden2;
    logic       mem_we2;
    logic       reg_write;
    logic [1:0] rf_wr_sel;
    logic       csr_we;
    logic       mret_exec;
    logic       is_load;
    logic       illegal;
  } ctrl_t;
endpackage

// File: rtl/otter_mc_fsm_if.sv
// otter_mc_fsm_if: decode fields in, datapath mux selects and write enables out
interface otter_mc_fsm_if;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic       br_taken;
  logic       intr;
  logic       mie;
  logic       pc_write;
  logic [2:0] pc_sel;
  logic       ir_write;
  logic       mem_rden1;
  logic       mem_rden2;
  logic       mem_we2;
  logic       reg_write;
  logic [1:0] rf_wr_sel;
  logic       csr_we;
  logic       int_taken;
  logic       mret_exec;
  modport master (
    output opcode, func3, br_taken, intr, mie,
    input  pc_write, pc_sel, ir_write, mem_rden1, mem_rden2, mem_we2,
           reg_write, rf_wr_sel, csr_we, int_taken, mret_exec
  );
  modport slave (
    input  opcode, func3, br_taken, intr, mie,
    output pc_write, pc_sel, ir_write, mem_rden1, mem_rden2, mem_we2,
           reg_write, rf_wr_sel, csr_we, int_taken, mret_exec
  );
endinterface

// File: rtl/otter_mc_decode.sv
// otter_mc_decode: opcode/func3/br_taken to EXECUTE control word.
// ILLEGAL_TRAP_EN: unknown opcodes suppress all writes and request a trap instead of a NOP.
module otter_mc_decode
  import otter_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       br_taken,
  output ctrl_t      c
);
  always_comb begin
    c = '0;
    c.pc_write = 1'b1;
    c.pc_sel = PC_PLUS4;
    case (opcode)
      LUI, AUIPC, OP, OP_IMM: begin
        c.reg_write = 1'b1;
        c.rf_wr_sel = RF_ALU;
      end
      JAL: begin
        c.reg_write = 1'b1;
        c.pc_sel = PC_JAL;
      end
      JALR: begin
        c.reg_write = 1'b1;
        c.pc_sel = PC_JALR;
      end
      BRANCH: c.pc_sel = br_taken ? PC_BRANCH : PC_PLUS4;
      STORE: c.mem_we2 = 1'b1;
      LOAD: begin
        c.mem_rden2 = 1'b1;
        c.pc_write = 1'b0;
        c.is_load = 1'b1;
      end
      SYSTEM: begin
        c.mret_exec = func3 == 3'd0;
        c.pc_sel = func3 == 3'd0 ? PC_TRAP : PC_PLUS4;
        c.csr_we = func3 != 3'd0;
        c.reg_write = func3 != 3'd0;
        c.rf_wr_sel = func3 != 3'd0 ? RF_CSR : RF_PC4;
      end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        c.pc_write = 1'b0;
        c.illegal = 1'b1;
`else
        c.pc_write = 1'b1;
`endif
      end
    endcase
  end
endmodule

// File: rtl/otter_mc_fsm.sv
// otter_mc_fsm: multicycle FETCH/DECODE/EXECUTE/WB/TRAP control for the OTTER core.
// ILLEGAL_TRAP_EN (in otter_mc_decode) routes unknown opcodes to TRAP.
module otter_mc_fsm
  import otter_pkg::*;
(
  input logic CLK,
  input logic RST,
  otter_mc_fsm_if.slave bus
);
  state_t state, nxt;
  ctrl_t c;
  logic trap_req;
  otter_mc_decode u_dec (.opcode(bus.opcode), .func3(bus.func3), .br_taken(bus.br_taken), .c(c));
  assign trap_req = bus.intr & bus.mie;
  always_ff @(posedge CLK) state <= RST ? FETCH : nxt;
  always_comb begin
    nxt = FETCH;
    bus.pc_write = 1'b0;
    bus.pc_sel = PC_PLUS4;
    bus.ir_write = 1'b0;
    bus.mem_rden1 = 1'b0;
    bus.mem_rden2 = 1'b0;
    bus.mem_we2 = 1'b0;
    bus.reg_write = 1'b0;
    bus.rf_wr_sel = RF_PC4;
    bus.csr_we = 1'b0;
    bus.int_taken = 1'b0;
    bus.mret_exec = 1'b0;
    if (!RST)
      case (state)
        FETCH: begin
          bus.mem_rden1 = 1'b1;
          nxt = DECODE;
        end
        DECODE: begin
          bus.ir_write = 1'b1;
          nxt = EXECUTE;
        end
        EXECUTE: begin
          bus.pc_write = c.pc_write;
          bus.pc_sel = c.pc_sel;
          bus.mem_rden2 = c.mem_rden2;
          bus.mem_we2 = c.mem_we2;
          bus.reg_write = c.reg_write;
          bus.rf_wr_sel = c.rf_wr_sel;
          bus.csr_we = c.csr_we;
          bus.mret_exec = c.mret_exec;
          nxt = c.is_load ? WB : (c.illegal || trap_req) ? TRAP : FETCH;
        end
        WB: begin
          bus.reg_write = 1'b1;
          bus.rf_wr_sel = RF_DMEM;
          bus.pc_write = 1'b1;
          nxt = trap_req ? TRAP : FETCH;
        end
        TRAP: begin
          bus.pc_write = 1'b1;
          bus.pc_sel = PC_TRAP;
          bus.int_taken = 1'b1;
        end
        default: nxt = FETCH;
      endcase
  end
endmodule

// File: tb/tb_otter_mc_fsm.sv
// tb_otter_mc_fsm: directed per-cycle checks of the multicycle control FSM outputs
module tb_otter_mc_fsm;
  import otter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  otter_mc_fsm_if bus ();
  otter_mc_fsm dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  // packed as pc_write, pc_sel, ir_write, mem_rden1, mem_rden2, mem_we2, reg_write, rf_wr_sel, csr_we, int_taken, mret_exec
  logic [13:0] outs;
  assign outs = {bus.pc_write, bus.pc_sel, bus.ir_write, bus.mem_rden1, bus.mem_rden2, bus.mem_we2,
                 bus.reg_write, bus.rf_wr_sel, bus.csr_we, bus.int_taken, bus.mret_exec};
  localparam logic [13:0] Z    = 14'b0_000_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] F    = 14'b0_000_0_1_0_0_0_00_0_0_0;
  localparam logic [13:0] D    = 14'b0_000_1_0_0_0_0_00_0_0_0;
  localparam logic [13:0] EOP  = 14'b1_000_0_0_0_0_1_11_0_0_0;
  localparam logic [13:0] ELD  = 14'b0_000_0_0_1_0_0_00_0_0_0;
  localparam logic [13:0] W    = 14'b1_000_0_0_0_0_1_10_0_0_0;
  localparam logic [13:0] EBT  = 14'b1_010_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] ENOP = 14'b1_000_0_0_0_0_0_00_0_0_0;
  localparam logic [13:0] EST  = 14'b1_000_0_0_0_1_0_00_0_0_0;
  localparam logic [13:0] EJAL = 14'b1_011_0_0_0_0_1_00_0_0_0;
  localparam logic [13:0] EJLR = 14'b1_001_0_0_0_0_1_00_0_0_0;
  localparam logic [13:0] ECSR = 14'b1_000_0_0_0_0_1_01_1_0_0;
  localparam logic [13:0] EMRT = 14'b1_100_0_0_0_0_0_00_0_0_1;
  localparam logic [13:0] TR   = 14'b1_100_0_0_0_0_0_00_0_1_0;

  task automatic set(input logic [6:0] op, input logic [2:0] f3, input logic br, input logic ir, input logic me);
    bus.opcode = op;
    bus.func3 = f3;
    bus.br_taken = br;
    bus.intr = ir;
    bus.mie = me;
  endtask

  task automatic test_reset();
    logic [13:0] e [8];
    logic r [8];
    e = '{Z, Z, F, D, EOP, Z, Z, F};
    r = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    set(OP, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      rst = r[i];
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL reset cyc%0d got %b want %b", i, outs, e[i]);
      end
      if (i < 7) @(negedge clk);
    end
  endtask

  task automatic test_op();
    logic [13:0] e [4];
    e = '{F, D, EOP, F};
    set(OP, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL op cyc%0d got %b want %b", i, outs, e[i]);
      end
      if (i < 3) @(negedge clk);
    end
  endtask

  task automatic test_load();
    logic [13:0] e [5];
    e = '{F, D, ELD, W, F};
    set(LOAD, 3'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL load cyc%0d got %b want %b", i, outs, e[i]);
      end
      if (i < 4) @(negedge clk);
    end
  endtask

  task automatic test_branch();
    logic [13:0] e [7];
    e = '{F, D, EBT, F, D, ENOP, F};
    for (int i = 0; i < 7; i++) begin
      if (i == 0) set(BRANCH, 3'd0, 1'b1, 1'b0, 1'b0);
      if (i == 3) set(BRANCH, 3'd1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL branch cyc%0d got %b want %b", i, outs, e[i]);
      end
      if (i < 6) @(negedge clk);
    end
  endtask

  task automatic test_jumps_store_csr();
    logic [13:0] e [13];
    e = '{F, D, EJAL, F, D, EJLR, F, D, EST, F, D, ECSR, F};
    for (int i = 0; i < 13; i++) begin
      if (i == 0) set(JAL, 3'd0, 1'b0, 1'b1, 1'b0);
      if (i == 3) set(JALR, 3'd0, 1'b1, 1'b0, 1'b1);
      if (i == 6) set(STORE, 3'd2, 1'b0, 1'b0, 1'b0);
      if (i == 9) set(SYSTEM, 3'd1, 1'b0, 1'b0, 1'b0);
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL jmp_st_csr cyc%0d got %b want %b", i, outs, e[i]);
      end
      if (i < 12) @(negedge clk);
    end
  endtask

  task automatic test_interrupt();
    logic [13:0] e [8];
    e = '{F, D, EOP, TR, F, D, EOP, F};
    for (int i = 0; i < 8; i++) begin
      if (i == 0) set(OP_IMM, 3'd0, 1'b0, 1'b1, 1'b1);
      if (i == 4) set(OP_IMM, 3'd0, 1'b0, 1'b1, 1'b0);
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL intr cyc%0d got %b want %b", i, outs, e[i]);
      end
      if (i < 7) @(negedge clk);
    end
  endtask

  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    logic [13:0] e [5];
    e = '{F, D, Z, TR, F};
`else
    logic [13:0] e [5];
    e = '{F, D, ENOP, F, D};
`endif
    set(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL illegal cyc%0d got %b want %b", i, outs, e[i]);
      end
      if (i < 4) @(negedge clk);
    end
`ifndef ILLEGAL_TRAP_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
  endtask

  task automatic test_back_to_back();
    logic [13:0] e [11];
    e = '{F, D, EMRT, TR, F, D, ELD, W, TR, F, D};
    for (int i = 0; i < 11; i++) begin
      if (i == 0) set(SYSTEM, 3'd0, 1'b0, 1'b1, 1'b1);
      if (i == 4) set(LOAD, 3'd0, 1'b0, 1'b1, 1'b1);
      if (i == 8) set(OP, 3'd0, 1'b0, 1'b1, 1'b1);
      #1;
      checks++;
      if (outs !== e[i]) begin
        errors++;
        $display("FAIL b2b cyc%0d got %b want %b", i, outs, e[i]);
      end
      if (i < 10) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_op();
    test_load();
    test_branch();
    test_jumps_store_csr();
    test_interrupt();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
